// File: rtl/fixed_point_pkg.sv
// Shared fixed-point definitions for the square-root / squaring datapath.
package fixed_point_pkg;

  localparam int ROOT_W     = 12;          // significant root bits (Q8.4)
  localparam int FRAC_BITS  = 4;           // fractional bits of the root
  localparam int OUT_W      = 16;          // integer square width
  localparam int ACC_W      = 2 * ROOT_W;  // full product width, never wraps
  localparam int CNT_W      = 4;           // enough to index ROOT_W bits
  localparam int ROOT_PORT_W = 16;         // root port width incl. must-be-zero bits

  // Q8.4 root as carried on the datapath; bits above ROOT_W are expected zero.
  typedef logic [ROOT_PORT_W-1:0] q8_4_root_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } sq_state_t;

endpackage

// File: rtl/fixed_square_step.sv
// One radix-2 shift-add step: conditionally add the shifted multiplicand.
module fixed_square_step
  import fixed_point_pkg::*;
(
  input  logic [ACC_W-1:0]  acc,
  input  logic [ROOT_W-1:0] mcand,
  input  logic              mult_bit,
  input  logic [CNT_W-1:0]  count,
  output logic [ACC_W-1:0]  acc_next
);

  logic [ACC_W-1:0] partial;

  // Partial product for this bit position, added only when the multiplier bit is set.
  always_comb begin
    partial  = ACC_W'(mcand) << count;
    acc_next = mult_bit ? (acc + partial) : acc;
  end

endmodule

// File: rtl/fixed_square.sv
// Sequential Q8.4 squaring unit: square = floor(root[11:0]^2 / 2^8), one root
// bit per clock with valid/ready on both sides.
// Optional: define FIXED_SQUARE_ROUND_EN for round-half-up (saturating) results.
module fixed_square
  import fixed_point_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROOT_PORT_W-1:0] root,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       square,
  output logic                   out_ovf
);

  sq_state_t         state_q,  state_d;
  logic [ACC_W-1:0]  acc_q,    acc_d;
  logic [ROOT_W-1:0] mcand_q,  mcand_d;
  logic [ROOT_W-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic              ovf_q,    ovf_d;
  logic [OUT_W-1:0]  square_q, square_d;
  logic              out_ovf_q, out_ovf_d;

  logic [ACC_W-1:0]  step_acc;
  logic [OUT_W-1:0]  result;

  fixed_square_step u_step (
    .acc      (step_acc_in()),
    .mcand    (mcand_q),
    .mult_bit (mplier_q[count_q]),
    .count    (count_q),
    .acc_next (step_acc)
  );

  function automatic logic [ACC_W-1:0] step_acc_in();
    return acc_q;
  endfunction

`ifdef FIXED_SQUARE_ROUND_EN
  logic [ACC_W:0] rnd_sum;

  // Round half up on the final accumulator, saturating if the sum no longer fits.
  always_comb begin
    rnd_sum = {1'b0, step_acc} + (ACC_W+1)'(1 << (2*FRAC_BITS-1));
    if (|rnd_sum[ACC_W:OUT_W+2*FRAC_BITS]) result = '1;
    else                                   result = rnd_sum[OUT_W+2*FRAC_BITS-1:2*FRAC_BITS];
  end
`else
  // Truncate the final accumulator to the integer part of the square.
  always_comb begin
    result = step_acc[OUT_W+2*FRAC_BITS-1:2*FRAC_BITS];
  end
`endif

  // Next-state and datapath control for the IDLE -> CALC -> DONE sequence.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path can infer a latch.
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    square_d  = square_q;
    out_ovf_d = out_ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = root[ROOT_W-1:0];
          mplier_d = root[ROOT_W-1:0];
          acc_d    = '0;
          count_d  = '0;
          ovf_d    = |root[ROOT_PORT_W-1:ROOT_W];
          state_d  = CALC;
        end
      end
      CALC: begin
        acc_d   = step_acc;
        count_d = count_q + 1'b1;
        // Data-independent: always runs all ROOT_W steps, no early exit.
        if (count_q == CNT_W'(ROOT_W-1)) begin
          count_d   = '0;
          square_d  = result;
          out_ovf_d = ovf_q;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      square_q  <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      square_q  <= square_d;
      out_ovf_q <= out_ovf_d;
    end
  end

  // Handshake outputs: ready only while idle and out of reset.
  always_comb begin
    in_ready  = (state_q == IDLE) && rst_n;
    out_valid = (state_q == DONE);
    square    = square_q;
    out_ovf   = out_ovf_q;
  end

endmodule
